mux_rr_sched: RTL
=================

# mux_rr_sched

Round-robin scheduler that drives the select and enable inputs of the 4:1 × 8-bit output multiplexer. It arbitrates four channel request lines, grants one channel at a time for a bounded burst of cycles, and presents the winner as a registered 2-bit select plus enable and a one-hot grant back to the requesters. It sits directly upstream of the mux: SEL and EN connect straight to the mux's SEL and EN inputs.

## Interface

- BURST, 4, maximum consecutive cycles per grant; legal range 1..255.
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- REQ  input  4  per-channel request; bit i belongs to mux input INi; level-sensitive.
- SEL  output  2  registered select to the mux; index of the granted channel.
- EN  output  1  registered mux enable; 1 while a grant is active.
- GNT  output  4  registered one-hot grant, equal to (EN ? 1<<SEL : 0).

## Operation

- Internal state:
  - FSM with two states, IDLE and GRANT.
  - 8-bit down-counter CNT.
  - 2-bit LAST pointer holding the most recently granted channel.
- Reset (RST=1, asynchronous) forces: IDLE, EN=0, SEL=0, GNT=0000, CNT=0, LAST=3. With LAST=3, the first arbitration favours channel 0.
- Arbitration:
  - Priority order is LAST+1, LAST+2, LAST+3, LAST (mod 4).
  - The first channel in that order with REQ set wins.
  - The current holder therefore ranks lowest but can still win if it is the only requester.
- IDLE:
  - If REQ==0000 at the edge: stay in IDLE; EN=0, GNT=0, SEL holds its last value.
  - Otherwise, at the edge: winner w is loaded into SEL and LAST, EN=1, GNT=1<<w, CNT=BURST-1, next state GRANT.
- GRANT:
  - The grant ends at the edge where CNT==0 or REQ[SEL]==0 is sampled.
  - Otherwise CNT decrements by 1 and SEL, EN and GNT hold.
- Grant end:
  - Arbitration runs in the same edge using the updated order (LAST = SEL).
  - If any REQ bit is set: the new winner is loaded with CNT=BURST-1 and the state stays GRANT. Handover has no idle bubble.
  - If REQ==0000: go to IDLE with EN=0, GNT=0000; SEL and LAST hold.
- REQ changes of non-granted channels during a grant do not shorten it.
- BURST=1:
  - CNT loads 0, so every grant lasts exactly one cycle.
  - With continuous requests, the grant rotates every cycle.
- CNT arithmetic is unsigned 8-bit. CNT never decrements below 0, because the release condition is checked first.

## Timing

- All outputs are registered; there are no combinational paths from REQ to SEL, EN or GNT.
- Grant latency from IDLE is 1 cycle: REQ sampled at edge n gives EN/SEL/GNT valid after edge n.
- Full-burst grant length is exactly BURST cycles of EN=1 per channel.
- Early release: with REQ[SEL] dropped before edge n, EN (or the grant) is still active in the cycle before edge n and changes after edge n. The mux therefore passes one extra cycle of the released channel; requesters must tolerate this.
- Reset mid-grant: outputs clear immediately on RST rising, with no clock needed. The first edge after RST falls arbitrates with LAST=3.
- SEL is only meaningful while EN=1. While EN=0 the mux outputs 0 regardless of SEL.

## Test plan

- Reset: assert RST with REQ=1111 -> EN=0, SEL=0, GNT=0000 immediately and throughout; release -> after the next edge, SEL=0, GNT=0001, EN=1.
- Single requester, BURST=4: hold REQ=0001 -> EN rises 1 cycle after the request and stays 1 continuously; SEL=0 throughout (regrant at each 4-cycle boundary, no gap).
- Full load, BURST=4: hold REQ=1111 -> SEL sequence 0,1,2,3,0, each value lasting exactly 4 cycles, with EN continuously 1 and GNT one-hot matching SEL.
- Early release: with ch2 granted, drop REQ=0000 after 2 cycles -> EN=0 and GNT=0000 after the following edge, SEL stays 2; then apply REQ=0101 -> ch0 is granted (order starts at 3).
- Async reset mid-grant: assert RST between edges during a ch1 grant -> EN, GNT and SEL clear without waiting for a clock; after release, REQ=0010 -> ch1 granted with a full BURST-cycle burst.
- BURST=1: hold REQ=1010 -> SEL alternates 1,3,1,3 every cycle with no EN gaps.

Source files
------------

// File: rtl/mux_rr_sched.sv
// mux_rr_sched
//   Round-robin scheduler driving the SEL/EN inputs of a 4:1 x 8-bit output mux.
//   Arbitrates four level-sensitive request lines. A winner holds the grant for
//   at most BURST consecutive cycles, or less if it drops its request. When a
//   grant ends and any request is pending, the next winner takes over on the
//   same edge, so there is no idle bubble. All outputs are registered.
//
// Parameters
//   BURST  maximum consecutive grant cycles per winner (1..255)
//
// Ports
//   CLK  in   1  system clock, rising edge
//   RST  in   1  asynchronous active-high reset
//   REQ  in   4  per-channel request, bit i belongs to mux input INi
//   SEL  out  2  registered mux select, index of the granted channel
//   EN   out  1  registered mux enable, high while a grant is active
//   GNT  out  4  registered one-hot grant, (EN ? 1<<SEL : 0)

module mux_rr_sched #(
    parameter int BURST = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    output logic [1:0] SEL,
    output logic       EN,
    output logic [3:0] GNT
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(BURST - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [1:0] last_q,  last_d;
    logic [1:0] sel_q,   sel_d;
    logic       en_q,    en_d;
    logic [3:0] gnt_q,   gnt_d;

    logic [1:0] arb_ptr;
    logic [1:0] win;
    logic       load;

    // First requester in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
    // The scan runs from lowest to highest priority so the last hit wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr,
                                           input logic [3:0] req);
        logic [1:0] w;
        logic [1:0] idx;
        w = ptr;
        for (int unsigned k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                w = idx;
            end
        end
        return w;
    endfunction

    // In GRANT the holder is the most recent winner, so the order restarts at SEL.
    assign arb_ptr = (state_q == GRANT) ? sel_q : last_q;
    assign win     = rr_pick(arb_ptr, REQ);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        en_d    = en_q;
        gnt_d   = gnt_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    load = 1'b1;
                end else begin
                    en_d  = 1'b0;
                    gnt_d = '0;
                end
            end
            GRANT: begin
                // Release is tested before the decrement, so CNT never wraps.
                if (cnt_q == 8'd0 || !REQ[sel_q]) begin
                    if (|REQ) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        gnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d = GRANT;
            sel_d   = win;
            last_d  = win;
            en_d    = 1'b1;
            gnt_d   = 4'b0001 << win;
            cnt_d   = CNT_LOAD;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 2'd3;
            sel_q   <= '0;
            en_q    <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            gnt_q   <= gnt_d;
        end
    end

    assign SEL = sel_q;
    assign EN  = en_q;
    assign GNT = gnt_q;

endmodule
